// File: rtl/pipelined_adder.sv
// pipelined_adder: carry-chain adder split into CHUNK-bit register stages with valid/ready flow control.
// Optional signed-overflow output enabled by defining PIPELINED_ADDER_OVF_EN.
module pipelined_adder #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic             i_carry,
    input  logic [WIDTH-1:0] i_data0,
    input  logic [WIDTH-1:0] i_data1,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_sum,
    output logic             o_carry
`ifdef PIPELINED_ADDER_OVF_EN
    ,
    output logic             o_overflow
`endif
);

    localparam int STAGES = (WIDTH + CHUNK - 1) / CHUNK;

    logic advance;

    // The whole pipeline moves as one; bubbles are never collapsed.
    assign advance = ~o_valid | i_ready;
    assign o_ready = advance;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam int LO = k * CHUNK;
        localparam int HI = (LO + CHUNK > WIDTH) ? WIDTH - 1 : LO + CHUNK - 1;
        localparam int CW = HI - LO + 1;

        logic [WIDTH-1:0] a_in, b_in, s_in, s_next, s_q;
        logic             c_in, v_in, load, c_q, v_q;
        logic [CW:0]      part;

        if (k == 0) begin : g_head
            assign a_in = i_data0;
            assign b_in = i_data1;
            assign s_in = '0;
            assign c_in = i_carry;
            assign v_in = i_valid;
            assign load = advance & i_valid;
        end else begin : g_body
            assign a_in = g_stage[k-1].g_skew.a_q;
            assign b_in = g_stage[k-1].g_skew.b_q;
            assign s_in = g_stage[k-1].s_q;
            assign c_in = g_stage[k-1].c_q;
            assign v_in = g_stage[k-1].v_q;
            assign load = advance;
        end

        assign part = {1'b0, a_in[HI:LO]} + {1'b0, b_in[HI:LO]} + (CW + 1)'(c_in);

        // Lower chunks already summed pass through; only this chunk is replaced.
        always_comb begin
            s_next        = s_in;
            s_next[HI:LO] = part[CW-1:0];
        end

        always_ff @(posedge i_clk or negedge i_rst_n) begin
            if (!i_rst_n) begin
                v_q <= 1'b0;
                c_q <= 1'b0;
                s_q <= '0;
            end else begin
                if (advance) v_q <= v_in;
                if (load) begin
                    c_q <= part[CW];
                    s_q <= s_next;
                end
            end
        end

        if (k < STAGES - 1) begin : g_skew
            logic [WIDTH-1:0] a_q, b_q;
            always_ff @(posedge i_clk or negedge i_rst_n) begin
                if (!i_rst_n) begin
                    a_q <= '0;
                    b_q <= '0;
                end else if (load) begin
                    a_q <= a_in;
                    b_q <= b_in;
                end
            end
        end

`ifdef PIPELINED_ADDER_OVF_EN
        if (k == STAGES - 1) begin : g_ovf
            logic ov_q;
            // Carry into the MSB is recovered as a ^ b ^ sum at that bit.
            always_ff @(posedge i_clk or negedge i_rst_n) begin
                if (!i_rst_n)
                    ov_q <= 1'b0;
                else if (load)
                    ov_q <= a_in[HI] ^ b_in[HI] ^ s_next[HI] ^ part[CW];
            end
        end
`endif
    end

    assign o_valid = g_stage[STAGES-1].v_q;
    assign o_sum   = g_stage[STAGES-1].s_q;
    assign o_carry = g_stage[STAGES-1].c_q;
`ifdef PIPELINED_ADDER_OVF_EN
    assign o_overflow = g_stage[STAGES-1].g_ovf.ov_q;
`endif

endmodule

// File: tb/tb_pipelined_adder.sv
// tb_pipelined_adder: random and directed stimulus against a slot-level reference model of the adder pipeline.
module tb_pipelined_adder;
    localparam int W = 8;
    localparam int C = 4;
    localparam int S = (W + C - 1) / C;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         i_valid = 1'b0;
    logic         i_ready = 1'b1;
    logic         i_carry = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         o_ready, o_valid, o_carry;
    logic [W-1:0] o_sum;
`ifdef PIPELINED_ADDER_OVF_EN
    logic         o_overflow;
`endif

    int passed = 0;
    int total  = 0;

    // Reference model: one entry per pipeline slot, holding the full arithmetic result.
    logic         mv [S];
    logic [W:0]   mr [S];
    logic         mo [S];

    pipelined_adder #(.WIDTH(W), .CHUNK(C)) dut (
        .i_clk(clk),
        .i_rst_n(rst_n),
        .i_valid(i_valid),
        .o_ready(o_ready),
        .i_carry(i_carry),
        .i_data0(a),
        .i_data1(b),
        .o_valid(o_valid),
        .i_ready(i_ready),
        .o_sum(o_sum),
        .o_carry(o_carry)
`ifdef PIPELINED_ADDER_OVF_EN
        ,
        .o_overflow(o_overflow)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
        a = x;
        b = y;
        i_carry = c;
        i_valid = 1'b1;
        tick();
        i_valid = 1'b0;
    endtask

    always @(negedge clk) begin
        logic       adv;
        logic [W:0] full;
        if (!rst_n) begin
            for (int i = 0; i < S; i++) mv[i] = 1'b0;
            check("rst_valid", 32'(o_valid), 32'd0);
            check("rst_sum", 32'(o_sum), 32'd0);
            check("rst_carry", 32'(o_carry), 32'd0);
`ifdef PIPELINED_ADDER_OVF_EN
            check("rst_ovf", 32'(o_overflow), 32'd0);
`endif
        end else begin
            adv = !mv[S-1] || i_ready;
            check("model_ready", 32'(o_ready), 32'(adv));
            check("model_valid", 32'(o_valid), 32'(mv[S-1]));
            if (mv[S-1]) begin
                check("model_result", 32'({o_carry, o_sum}), 32'(mr[S-1]));
`ifdef PIPELINED_ADDER_OVF_EN
                check("model_ovf", 32'(o_overflow), 32'(mo[S-1]));
`endif
            end
            if (adv) begin
                for (int i = S - 1; i > 0; i--) begin
                    mv[i] = mv[i-1];
                    mr[i] = mr[i-1];
                    mo[i] = mo[i-1];
                end
                full  = {1'b0, a} + {1'b0, b} + (W + 1)'(i_carry);
                mv[0] = i_valid;
                mr[0] = full;
                mo[0] = (a[W-1] == b[W-1]) && (full[W-1] != a[W-1]);
            end
        end
    end

    initial begin
        logic [W-1:0] stream_exp [3];
        stream_exp = '{8'h02, 8'h04, 8'h06};

        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        tick();
        check("idle_valid", 32'(o_valid), 32'd0);
        check("idle_sum", 32'(o_sum), 32'd0);
        check("idle_carry", 32'(o_carry), 32'd0);
        check("idle_ready", 32'(o_ready), 32'd1);

        send(8'h0F, 8'h01, 1'b0);
        check("lat_early", 32'(o_valid), 32'd0);
        tick();
        check("lat_valid", 32'(o_valid), 32'd1);
        check("chunk_carry_sum", 32'(o_sum), 32'h10);
        check("chunk_carry_cout", 32'(o_carry), 32'd0);
        tick();

        send(8'hFF, 8'hFF, 1'b1);
        tick();
        check("allones_sum", 32'(o_sum), 32'hFF);
        check("allones_cout", 32'(o_carry), 32'd1);
        tick();

        send(8'h7F, 8'h01, 1'b0);
        tick();
        check("ovf_sum", 32'(o_sum), 32'h80);
        check("ovf_cout", 32'(o_carry), 32'd0);
`ifdef PIPELINED_ADDER_OVF_EN
        check("ovf_flag", 32'(o_overflow), 32'd1);
`endif
        tick();

        for (int i = 1; i <= 3; i++) begin
            a = W'(i);
            b = W'(i);
            i_carry = 1'b0;
            i_valid = 1'b1;
            tick();
            if (i >= 2) check("stream_sum", 32'(o_sum), 32'(stream_exp[i-2]));
        end
        i_valid = 1'b0;
        tick();
        check("stream_last", 32'(o_sum), 32'(stream_exp[2]));
        check("stream_last_valid", 32'(o_valid), 32'd1);
        tick();
        check("stream_empty", 32'(o_valid), 32'd0);

        i_ready = 1'b0;
        a = 8'h10; b = 8'h01; i_valid = 1'b1;
        tick();
        a = 8'h20; b = 8'h02;
        tick();
        a = 8'h30; b = 8'h03;
        for (int i = 0; i < 5; i++) begin
            check("stall_ready", 32'(o_ready), 32'd0);
            check("stall_valid", 32'(o_valid), 32'd1);
            check("stall_sum", 32'(o_sum), 32'h11);
            tick();
        end
        i_ready = 1'b1;
        tick();
        check("drain_first", 32'(o_sum), 32'h22);
        i_valid = 1'b0;
        tick();
        check("drain_second", 32'(o_sum), 32'h33);
        check("drain_second_valid", 32'(o_valid), 32'd1);
        tick();
        check("drain_empty", 32'(o_valid), 32'd0);

        send(8'h05, 8'h06, 1'b0);
        send(8'h07, 8'h08, 1'b1);
        check("pre_reset_valid", 32'(o_valid), 32'd1);
        #1 rst_n = 1'b0;
        #1;
        check("async_rst_valid", 32'(o_valid), 32'd0);
        check("async_rst_sum", 32'(o_sum), 32'd0);
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("no_stale", 32'(o_valid), 32'd0);
        end

        for (int n = 0; n < 1500; n++) begin
            i_valid = ($urandom % 4) != 0;
            i_ready = ($urandom % 3) != 0;
            case ($urandom % 8)
                0: begin a = '1; b = '1; end
                1: begin a = '0; b = '0; end
                default: begin a = W'($urandom); b = W'($urandom); end
            endcase
            i_carry = 1'($urandom);
            tick();
        end
        i_valid = 1'b0;
        i_ready = 1'b1;
        repeat (S + 2) tick();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
